shift_unit_seq: RTL and testbench
=================================

# shift_unit_seq

Parametrised multi-cycle shifter for the processor's ALU shift path: logical left, logical right, arithmetic right and, optionally, rotate right of a WIDTH-bit operand by a variable amount. It moves one bit position per clock under a small FSM with a start/done handshake, trading latency for area against a full barrel shifter. The ALU or a multicycle controller issues `start` and stalls on `ready` and `done`.

## Interface
- `WIDTH`, default 32: operand width; must be a power of two, at least 2.
- `SHAMT_W`, default 5: shift-amount width; must equal log2(WIDTH).
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: request; sampled only when `ready`=1.
- `op` in 2: 00 SLL, 01 SRL, 10 SRA, 11 ROR (requires the configuration macro).
- `shamt` in SHAMT_W: shift amount, 0..WIDTH-1.
- `din` in WIDTH: operand.
- `ready` out 1: can accept `start` (state != RUN).
- `busy` out 1: state == RUN.
- `done` out 1: one-cycle pulse, `result` valid.
- `result` out WIDTH: shifted value; held until the next accepted `start`.
- `err` out 1: illegal op; valid with `done`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- **IDLE or DONE with `start`=1:**
  - Capture `din` into the data register, `shamt` into the count register, and `op`.
  - Next state is RUN.
- **IDLE or DONE with `start`=0:** IDLE → IDLE; DONE → IDLE.
- **RUN with count != 0:**
  - Shift the data register by one position; decrement count.
  - Fill bits: SLL shifts left with a 0 fill. SRL shifts right with a 0 fill. SRA shifts right and copies bit WIDTH-1. ROR shifts right and moves bit 0 into bit WIDTH-1.
- **RUN with count == 0:**
  - Copy the data register to `result`.
  - Next state is DONE.
- `done` = (state == DONE). `err` is registered with `result` and is cleared on the next accepted `start`.
- `start` while in RUN is ignored; it is not queued.
- Operand inputs are sampled only at the accepting edge. Later changes have no effect.
- SRA by WIDTH-1: `result` is all copies of `din[WIDTH-1]`.

## Timing
- Reset values:
  - `ready`=1, `busy`=0, `done`=0, `err`=0, `result`=0.
  - Data and count registers are 0; state is IDLE.
- Latency: the `start` accepted at edge E0 gives `done`=1 in the cycle following edge E(shamt+1). Total: shamt+1 cycles; worst case WIDTH cycles.
- `busy` is high for shamt+1 cycles.
- `ready`:
  - Low exactly while `busy` is high.
  - High during the DONE cycle, so back-to-back operations have no idle bubble.
- `start` in the DONE cycle: `done` stays high for that cycle only. The new operation enters RUN at the next edge.
- `reset` mid-operation:
  - Immediately forces IDLE and all reset values; the operation is discarded.
  - `done` must not pulse for it.

## Configuration
- `SHIFT_UNIT_ROTATE_EN` defined:
  - `op`=11 performs rotate right by `shamt`, with normal latency and `err`=0.
- `SHIFT_UNIT_ROTATE_EN` undefined:
  - `op`=11 is illegal. It is accepted, count is forced to 0, and no shift occurs.
  - `done` follows after 1 cycle with `result`=`din` and `err`=1.
  - No rotate logic is synthesised.

## Test plan
- **SRA:** `din`=0x80000000, `op`=10, `shamt`=1 → `result`=0xC0000000, `done` 2 cycles after accept, `err`=0. Then `din`=0x7FFFFFF0, `shamt`=4 → `result`=0x07FFFFFF.
- **SRL and SLL:**
  - `din`=0x80000000, `op`=01, `shamt`=31 → `result`=0x00000001, `done` at cycle 32, `busy` high for 32 cycles.
  - `op`=00, `din`=0x00000001, `shamt`=31 → `result`=0x80000000.
- **Zero shift and back-to-back:**
  - `op`=00, `shamt`=0, `din`=0xDEADBEEF → `result`=0xDEADBEEF after 1 cycle.
  - A new `start` (SRA, `din`=0xF0000000, `shamt`=8) in the DONE cycle → `result`=0xFFF00000 9 cycles later, with no idle cycle in between.
- **Ignored start:** `start` pulses in RUN with a different `din` → no effect; `result` matches the first operation; exactly one `done` pulse.
- **Reset mid-operation:** assert `reset` 3 cycles into a 20-bit shift → all outputs take reset values asynchronously, no `done` pulse, `ready`=1. A following operation completes correctly.
- **Rotate:** `op`=11, `din`=0x00000003, `shamt`=1.
  - With the macro: `result`=0x80000001, `err`=0, `done` after 2 cycles.
  - Without the macro: `result`=0x00000003, `err`=1, `done` after 1 cycle.

Source files
------------

// File: rtl/shift_unit_seq_if.sv
// Request/response bundle for the sequential shifter: operand, shift
// amount and operation in, status flags and result out.
interface shift_unit_seq_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);
   logic               start;
   logic [1:0]         op;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   din;
   logic               ready;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   result;
   logic               err;

   modport master (
      output start, op, shamt, din,
      input  ready, busy, done, result, err
   );

   modport slave (
      input  start, op, shamt, din,
      output ready, busy, done, result, err
   );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter: SLL / SRL / SRA (and ROR when SHIFT_UNIT_ROTATE_EN
// is defined), one bit position per clock, start/done handshake.
// Without SHIFT_UNIT_ROTATE_EN, op 11 completes in one cycle with err set
// and the operand passed through unchanged.
module shift_unit_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clock,
   input  logic               reset,
   shift_unit_seq_if.slave    bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef SHIFT_UNIT_ROTATE_EN
   localparam bit ROT_ILLEGAL = 1'b0;
`else
   localparam bit ROT_ILLEGAL = 1'b1;
`endif

   localparam logic [SHAMT_W-1:0] COUNT_ONE = SHAMT_W'(1);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   data_q;
   logic [SHAMT_W-1:0] count_q;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   result_q;
   logic               err_q;
   logic               accept;

   // op 11 is only legal when the rotate path is built
   function automatic logic is_illegal(input logic [1:0] o);
      return (o == 2'b11) && ROT_ILLEGAL;
   endfunction

   // One-bit shift step with the fill rule of each operation
   function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] d,
                                                  input logic [1:0]       o);
      logic signed [WIDTH-1:0] sd;
      sd = d;
      case (o)
         2'b00:   shift_one = {d[WIDTH-2:0], 1'b0};
         2'b01:   shift_one = {1'b0, d[WIDTH-1:1]};
         2'b10:   shift_one = sd >>> 1;
`ifdef SHIFT_UNIT_ROTATE_EN
         2'b11:   shift_one = {d[0], d[WIDTH-1:1]};
`endif
         default: shift_one = d;
      endcase
   endfunction

   // A new request is taken whenever the unit is not mid-shift, including DONE
   assign accept = bus.start && (state != RUN);

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: state_nxt = bus.start ? RUN : IDLE;
         RUN:        if (count_q == '0) state_nxt = DONE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Operand capture, bit-serial shifting and result/err registration
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_q   <= '0;
         count_q  <= '0;
         op_q     <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else if (accept) begin
         data_q  <= bus.din;
         count_q <= is_illegal(bus.op) ? '0 : bus.shamt;
         op_q    <= bus.op;
         err_q   <= 1'b0;
      end else if (state == RUN) begin
         if (count_q != '0) begin
            data_q  <= shift_one(data_q, op_q);
            count_q <= count_q - COUNT_ONE;
         end else begin
            result_q <= data_q;
            err_q    <= is_illegal(op_q);
         end
      end
   end

   assign bus.ready  = (state != RUN);
   assign bus.busy   = (state == RUN);
   assign bus.done   = (state == DONE);
   assign bus.result = result_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: directed cases plus randomized operations
// compared against an arithmetic reference model. Honours
// SHIFT_UNIT_ROTATE_EN the same way the design does.
module tb_shift_unit_seq;

   localparam int W  = 32;
   localparam int SW = 5;

   logic clock;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   shift_unit_seq_if #(.WIDTH(W), .SHAMT_W(SW)) sif ();

   shift_unit_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (sif)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference model: whole-amount shifts with plain operators
   function automatic logic [31:0] m_res(input logic [1:0] o, input int s, input logic [31:0] d);
      logic signed [31:0] sd;
      sd = d;
      case (o)
         2'd0: return d << s;
         2'd1: return d >> s;
         2'd2: return sd >>> s;
         default: begin
`ifdef SHIFT_UNIT_ROTATE_EN
            if (s == 0) return d;
            return (d >> s) | (d << (W - s));
`else
            return d;
`endif
         end
      endcase
   endfunction

   function automatic logic m_err(input logic [1:0] o);
`ifdef SHIFT_UNIT_ROTATE_EN
      return 1'b0;
`else
      return o == 2'd3;
`endif
   endfunction

   function automatic int m_lat(input logic [1:0] o, input int s);
      return m_err(o) ? 1 : s + 1;
   endfunction

   // Present a request at a negedge; returns at the negedge after the accepting edge
   task automatic issue(input logic [1:0] o, input int s, input logic [31:0] d);
      logic [4:0] sa;
      sa = s[4:0];
      chk("ready_at_issue", sif.ready, 1);
      sif.start = 1'b1;
      sif.op    = o;
      sif.shamt = sa;
      sif.din   = d;
      @(negedge clock);
      sif.start = 1'b0;
      sif.din   = $urandom;
      sif.shamt = 5'($urandom);
      sif.op    = 2'($urandom);
      chk("busy_after_accept", sif.busy, 1);
      chk("done_after_accept", sif.done, 0);
   endtask

   // Wait for done, checking latency, busy length, ready, result and err
   task automatic wait_done(input string tag, input logic [31:0] exp_res, input logic exp_err,
                            input int exp_lat, input bit poke);
      int cyc;
      int busy_cnt;
      cyc = 0;
      busy_cnt = 0;
      while (!sif.done && cyc < 100) begin
         if (sif.busy) busy_cnt++;
         if (sif.ready === sif.busy) chk({tag, "_ready_vs_busy"}, sif.ready, ~sif.busy);
         sif.start = poke && (cyc == 2);
         if (poke && cyc == 2) sif.din = ~exp_res;
         @(negedge clock);
         cyc++;
      end
      sif.start = 1'b0;
      chk({tag, "_done_seen"}, sif.done, 1);
      chk({tag, "_latency"}, cyc, exp_lat);
      chk({tag, "_busy_len"}, busy_cnt, exp_lat);
      chk({tag, "_result"}, sif.result, exp_res);
      chk({tag, "_err"}, sif.err, exp_err);
      chk({tag, "_ready_in_done"}, sif.ready, 1);
   endtask

   task automatic expect_idle_after_done(input string tag);
      @(negedge clock);
      chk({tag, "_done_one_cycle"}, sif.done, 0);
   endtask

   initial begin
      logic [1:0]  o;
      int          s;
      logic [31:0] d;
      clock     = 1'b0;
      reset     = 1'b1;
      sif.start = 1'b0;
      sif.op    = 2'd0;
      sif.shamt = '0;
      sif.din   = '0;
      repeat (2) @(negedge clock);
      chk("rst_ready", sif.ready, 1);
      chk("rst_busy", sif.busy, 0);
      chk("rst_done", sif.done, 0);
      chk("rst_err", sif.err, 0);
      chk("rst_result", sif.result, 0);
      reset = 1'b0;
      @(negedge clock);

      // SRA
      issue(2'd2, 1, 32'h8000_0000);
      wait_done("sra1", 32'hC000_0000, 1'b0, 2, 1'b0);
      expect_idle_after_done("sra1");
      issue(2'd2, 4, 32'h7FFF_FFF0);
      wait_done("sra4", 32'h07FF_FFFF, 1'b0, 5, 1'b0);
      expect_idle_after_done("sra4");

      // SRL / SLL worst case
      issue(2'd1, 31, 32'h8000_0000);
      wait_done("srl31", 32'h0000_0001, 1'b0, 32, 1'b0);
      expect_idle_after_done("srl31");
      issue(2'd0, 31, 32'h0000_0001);
      wait_done("sll31", 32'h8000_0000, 1'b0, 32, 1'b0);
      expect_idle_after_done("sll31");
      issue(2'd2, 31, 32'h9000_0000);
      wait_done("sra31", 32'hFFFF_FFFF, 1'b0, 32, 1'b0);
      expect_idle_after_done("sra31");

      // Zero shift then back-to-back in DONE cycle
      issue(2'd0, 0, 32'hDEAD_BEEF);
      wait_done("zero", 32'hDEAD_BEEF, 1'b0, 1, 1'b0);
      issue(2'd2, 8, 32'hF000_0000);
      wait_done("b2b", 32'hFFF0_0000, 1'b0, 9, 1'b0);
      expect_idle_after_done("b2b");

      // Ignored start while running
      issue(2'd1, 10, 32'hA5A5_0000);
      wait_done("ignored", 32'h0029_6940, 1'b0, 11, 1'b1);
      expect_idle_after_done("ignored");

      // Rotate / illegal op
      issue(2'd3, 1, 32'h0000_0003);
`ifdef SHIFT_UNIT_ROTATE_EN
      wait_done("ror", 32'h8000_0001, 1'b0, 2, 1'b0);
`else
      wait_done("ror_illegal", 32'h0000_0003, 1'b1, 1, 1'b0);
`endif
      expect_idle_after_done("ror");
      issue(2'd0, 3, 32'h0000_0011);
      wait_done("err_clear", 32'h0000_0088, 1'b0, 4, 1'b0);
      expect_idle_after_done("err_clear");

      // Reset mid-operation
      issue(2'd0, 20, 32'h0000_0F0F);
      repeat (3) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_ready", sif.ready, 1);
      chk("mid_rst_busy", sif.busy, 0);
      chk("mid_rst_done", sif.done, 0);
      chk("mid_rst_err", sif.err, 0);
      chk("mid_rst_result", sif.result, 0);
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clock);
         if (sif.done) chk("mid_rst_no_done", sif.done, 0);
      end
      chk("post_rst_ready", sif.ready, 1);
      issue(2'd1, 5, 32'h1234_5678);
      wait_done("post_rst", 32'h0091_A2B3, 1'b0, 6, 1'b0);
      expect_idle_after_done("post_rst");

      // Randomized operations against the model
      for (int n = 0; n < 40; n++) begin
         o = 2'($urandom_range(0, 3));
         s = $urandom_range(0, 31);
         d = $urandom;
         issue(o, s, d);
         wait_done("rand", m_res(o, s, d), m_err(o), m_lat(o, s), (s > 4) && (n % 3 == 0));
         if ($urandom_range(0, 1) == 1) expect_idle_after_done("rand");
      end
      @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
